// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID stage / downstream pipeline and the hazard scoreboard.
// The master modport is the pipeline side, the slave modport is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LAT_W      = 6,
  parameter int SEL_W      = $clog2(FWD_STAGES + 2)
);
  logic [REG_AW-1:0]            id_rs1_addr;
  logic [REG_AW-1:0]            id_rs2_addr;
  logic                         id_rs1_used;
  logic                         id_rs2_used;
  logic [REG_AW-1:0]            id_rd_addr;
  logic                         id_rd_we;
  logic                         id_mc_valid;
  logic [LAT_W-1:0]             id_mc_lat;
  logic [FWD_STAGES-1:0]        stage_we;
  logic [FWD_STAGES*REG_AW-1:0] stage_waddr;
  logic [FWD_STAGES-1:0]        stage_ready;
  logic [SEL_W-1:0]             fwd_sel_1;
  logic [SEL_W-1:0]             fwd_sel_2;
  logic                         stall;
  logic                         mc_issue;
  logic                         mc_done;
  logic [REG_AW-1:0]            mc_done_rd;
  logic [31:0]                  stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output id_rd_addr, id_rd_we, id_mc_valid, id_mc_lat,
    output stage_we, stage_waddr, stage_ready,
    input  fwd_sel_1, fwd_sel_2, stall, mc_issue, mc_done, mc_done_rd, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  id_rd_addr, id_rd_we, id_mc_valid, id_mc_lat,
    input  stage_we, stage_waddr, stage_ready,
    output fwd_sel_1, fwd_sel_2, stall, mc_issue, mc_done, mc_done_rd, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard controller beside ID: forwarding selects, load-use stalls, and a
// scoreboard for one variable-latency multi-cycle unit with a stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LAT_W      = 6,
  parameter int SEL_W      = $clog2(FWD_STAGES + 2)
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave hz
);
  localparam int NREGS = 2 ** REG_AW;
  localparam logic [SEL_W-1:0] SEL_RF = '0;
  localparam logic [SEL_W-1:0] SEL_MC = SEL_W'(FWD_STAGES + 1);

  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;

  mc_state_e         state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic              busy;
  logic              mc_done;
  logic              mc_issue;
  logic              stall;
  logic [SEL_W-1:0]  sel1, sel2;
  logic              pipe_wait1, pipe_wait2;
  logic              raw1, raw2, waw, structural;

  // Youngest matching stage wins; an older stage is never substituted when the
  // youngest match is not ready, so that case reports wait_rdy instead.
  function automatic void fwd_lookup(
    input  logic [REG_AW-1:0]            src,
    input  logic                         used,
    input  logic [FWD_STAGES-1:0]        we,
    input  logic [FWD_STAGES*REG_AW-1:0] waddr,
    input  logic [FWD_STAGES-1:0]        rdy,
    input  logic                         done,
    input  logic [REG_AW-1:0]            done_rd,
    output logic [SEL_W-1:0]             sel,
    output logic                         wait_rdy
  );
    logic hit;
    hit      = 1'b0;
    sel      = SEL_RF;
    wait_rdy = 1'b0;
    for (int unsigned i = 0; i < FWD_STAGES; i++) begin
      if (!hit && used && we[i] && (src != '0) &&
          (waddr[i*REG_AW +: REG_AW] == src)) begin
        hit      = 1'b1;
        sel      = SEL_W'(i + 1);
        wait_rdy = !rdy[i];
      end
    end
    if (!hit && used && (src != '0) && done && (done_rd == src)) begin
      sel = SEL_MC;
    end
  endfunction

  assign busy    = (state_q == MC_BUSY);
  assign mc_done = busy && (cnt_q == LAT_W'(1));

  always_comb begin
    fwd_lookup(hz.id_rs1_addr, hz.id_rs1_used, hz.stage_we, hz.stage_waddr,
               hz.stage_ready, mc_done, mc_rd_q, sel1, pipe_wait1);
    fwd_lookup(hz.id_rs2_addr, hz.id_rs2_used, hz.stage_we, hz.stage_waddr,
               hz.stage_ready, mc_done, mc_rd_q, sel2, pipe_wait2);
  end

  // A register completing this cycle is bypassed, so its pending bit is ignored.
  always_comb begin
    raw1 = hz.id_rs1_used && (hz.id_rs1_addr != '0) && pending_q[hz.id_rs1_addr] &&
           !(mc_done && (mc_rd_q == hz.id_rs1_addr));
    raw2 = hz.id_rs2_used && (hz.id_rs2_addr != '0) && pending_q[hz.id_rs2_addr] &&
           !(mc_done && (mc_rd_q == hz.id_rs2_addr));
    waw  = hz.id_rd_we && (hz.id_rd_addr != '0) && pending_q[hz.id_rd_addr] &&
           !(mc_done && (mc_rd_q == hz.id_rd_addr));
    structural = hz.id_mc_valid && busy && !mc_done;
  end

  assign stall    = pipe_wait1 || pipe_wait2 || raw1 || raw2 || waw || structural;
  assign mc_issue = hz.id_mc_valid && !stall;

  // Completion clears first so a same-cycle issue to the same register wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_rd_d   = mc_rd_q;
    pending_d = pending_q;
    if (mc_done) begin
      state_d            = MC_IDLE;
      cnt_d              = '0;
      pending_d[mc_rd_q] = 1'b0;
    end else if (busy) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
    if (mc_issue) begin
      state_d = MC_BUSY;
      cnt_d   = (hz.id_mc_lat == '0) ? LAT_W'(1) : hz.id_mc_lat;
      mc_rd_d = hz.id_rd_addr;
      if (hz.id_rd_we && (hz.id_rd_addr != '0)) begin
        pending_d[hz.id_rd_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= MC_IDLE;
      cnt_q          <= '0;
      mc_rd_q        <= '0;
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mc_rd_q        <= mc_rd_d;
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.fwd_sel_1    = sel1;
  assign hz.fwd_sel_2    = sel2;
  assign hz.stall        = stall;
  assign hz.mc_issue     = mc_issue;
  assign hz.mc_done      = mc_done;
  assign hz.mc_done_rd   = mc_rd_q;
  assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: table of forwarding vectors plus
// hand-written multi-cycle scoreboard, reset and saturation sequences.
module tb_hazard_scoreboard;
  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 3;
  localparam int LAT_W      = 6;
  localparam int MCSEL      = FWD_STAGES + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) hif();

  hazard_scoreboard #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_sc   = '0;

  typedef struct {
    string       name;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [2:0]  swe;
    logic [14:0] swa;
    logic [2:0]  srdy;
    int unsigned e_sel1;
    int unsigned e_sel2;
    logic        e_stall;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [14:0] wa(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] s0);
    return {s2, s1, s0};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    hif.id_rs1_addr = '0; hif.id_rs2_addr = '0;
    hif.id_rs1_used = 1'b0; hif.id_rs2_used = 1'b0;
    hif.id_rd_addr  = '0; hif.id_rd_we = 1'b0;
    hif.id_mc_valid = 1'b0; hif.id_mc_lat = '0;
    hif.stage_we    = '0; hif.stage_waddr = '0; hif.stage_ready = '0;
  endtask

  // Checks the combinational outputs for the current cycle, then advances one edge.
  task automatic chk(input string nm, input int unsigned s1, input int unsigned s2,
                     input logic st, input logic iss, input logic dn, input logic [4:0] drd);
    #1;
    cmp({nm, ".sel1"},  32'(hif.fwd_sel_1), s1);
    cmp({nm, ".sel2"},  32'(hif.fwd_sel_2), s2);
    cmp({nm, ".stall"}, 32'(hif.stall), 32'(st));
    cmp({nm, ".issue"}, 32'(hif.mc_issue), 32'(iss));
    cmp({nm, ".done"},  32'(hif.mc_done), 32'(dn));
    if (dn) cmp({nm, ".done_rd"}, 32'(hif.mc_done_rd), 32'(drd));
    if (st && exp_sc != '1) exp_sc = exp_sc + 32'd1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [5:0] lat);
    hif.id_mc_valid = 1'b1; hif.id_rd_addr = rd; hif.id_rd_we = 1'b1; hif.id_mc_lat = lat;
  endtask

  initial begin
    vecs[0] = '{"fwd_prio",   5, 1, 0, 0, 3'b101, wa(5, 0, 5), 3'b111, 1, 0, 1'b0};
    vecs[1] = '{"fwd_older",  5, 1, 0, 0, 3'b100, wa(5, 0, 5), 3'b111, 3, 0, 1'b0};
    vecs[2] = '{"load_use",   0, 0, 7, 1, 3'b001, wa(0, 0, 7), 3'b110, 0, 1, 1'b1};
    vecs[3] = '{"load_adv",   0, 0, 7, 1, 3'b010, wa(0, 7, 0), 3'b111, 0, 2, 1'b0};
    vecs[4] = '{"x0_dest",    0, 1, 0, 1, 3'b111, wa(0, 0, 0), 3'b000, 0, 0, 1'b0};
    vecs[5] = '{"unused_src", 5, 0, 0, 0, 3'b001, wa(0, 0, 5), 3'b000, 0, 0, 1'b0};
    vecs[6] = '{"two_src",    3, 1, 4, 1, 3'b110, wa(4, 3, 0), 3'b111, 2, 3, 1'b0};
    vecs[7] = '{"young_nrdy", 6, 1, 0, 0, 3'b011, wa(0, 6, 6), 3'b010, 1, 0, 1'b1};
    vecs[8] = '{"no_match",   8, 1, 9, 1, 3'b111, wa(1, 2, 3), 3'b111, 0, 0, 1'b0};

    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset", 0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    cmp("reset.stall_cycles", hif.stall_cycles, 32'd0);

    for (int i = 0; i < 9; i++) begin
      idle();
      hif.id_rs1_addr = vecs[i].rs1; hif.id_rs1_used = vecs[i].u1;
      hif.id_rs2_addr = vecs[i].rs2; hif.id_rs2_used = vecs[i].u2;
      hif.stage_we = vecs[i].swe; hif.stage_waddr = vecs[i].swa; hif.stage_ready = vecs[i].srdy;
      chk(vecs[i].name, vecs[i].e_sel1, vecs[i].e_sel2, vecs[i].e_stall, 1'b0, 1'b0, 5'd0);
    end
    cmp("table.stall_cycles", hif.stall_cycles, exp_sc);

    // Multi-cycle RAW: issue x9 lat 4, reader stalls 3 cycles, then bypasses.
    exp_sc = hif.stall_cycles === 32'd2 ? 32'd2 : exp_sc;
    idle(); issue(5'd9, 6'd4);
    chk("raw.issue", 0, 0, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      idle(); hif.id_rs1_addr = 5'd9; hif.id_rs1_used = 1'b1;
      chk("raw.wait", 0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
    end
    idle(); hif.id_rs1_addr = 5'd9; hif.id_rs1_used = 1'b1;
    chk("raw.done", MCSEL, 0, 1'b0, 1'b0, 1'b1, 5'd9);
    cmp("raw.stall_cycles", hif.stall_cycles, 32'd5);
    idle(); hif.id_rs1_addr = 5'd9; hif.id_rs1_used = 1'b1;
    chk("raw.after", 0, 0, 1'b0, 1'b0, 1'b0, 5'd0);

    // WAW then structural stall; second op issues in the first op's done cycle.
    idle(); issue(5'd10, 6'd3);
    chk("st.issue1", 0, 0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(); hif.id_rd_addr = 5'd10; hif.id_rd_we = 1'b1;
    chk("st.waw", 0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(); issue(5'd11, 6'd0);
    chk("st.busy", 0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(); issue(5'd11, 6'd0);
    chk("st.issue2", 0, 0, 1'b0, 1'b1, 1'b1, 5'd10);
    idle(); hif.id_rd_addr = 5'd11; hif.id_rd_we = 1'b1;
    hif.id_rs1_addr = 5'd11; hif.id_rs1_used = 1'b1;
    chk("st.lat0", MCSEL, 0, 1'b0, 1'b0, 1'b1, 5'd11);
    idle();
    chk("st.idle", 0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    cmp("st.stall_cycles", hif.stall_cycles, exp_sc);

    // rd=x0 op must not mark anything pending.
    idle(); issue(5'd0, 6'd2);
    chk("x0.issue", 0, 0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(); hif.id_rd_addr = 5'd0; hif.id_rd_we = 1'b1;
    hif.id_rs1_addr = 5'd0; hif.id_rs1_used = 1'b1;
    chk("x0.nostall", 0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    idle();
    chk("x0.done", 0, 0, 1'b0, 1'b0, 1'b1, 5'd0);

    // Reset during an outstanding op abandons it.
    idle(); issue(5'd12, 6'd5);
    chk("rst.issue", 0, 0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(); hif.id_rs1_addr = 5'd12; hif.id_rs1_used = 1'b1;
    chk("rst.wait", 0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_sc = '0;
    for (int c = 0; c < 8; c++) begin
      idle(); hif.id_rs1_addr = 5'd12; hif.id_rs1_used = 1'b1;
      chk("rst.after", 0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    end
    cmp("rst.stall_cycles", hif.stall_cycles, 32'd0);

    // Saturation: preload the counter near its ceiling, then stall repeatedly.
    idle();
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles_q;
    exp_sc = 32'hFFFF_FFFD;
    for (int c = 0; c < 4; c++) begin
      idle(); hif.id_rs2_addr = 5'd7; hif.id_rs2_used = 1'b1;
      hif.stage_we = 3'b001; hif.stage_waddr = wa(0, 0, 7); hif.stage_ready = 3'b000;
      chk("sat.stall", 0, 1, 1'b1, 1'b0, 1'b0, 5'd0);
      cmp("sat.stall_cycles", hif.stall_cycles, exp_sc);
    end
    cmp("sat.final", hif.stall_cycles, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
